// File: rtl/i2c_target.sv
// I2C target byte engine: filtered SCL/SDA, START/STOP detect, 7-bit address match, RX/TX byte handshakes.
// Define I2C_TARGET_STRETCH_EN to hold SCL low while waiting for read data.
module i2c_target #(
    parameter logic [6:0]  Address      = 7'h50,
    parameter int unsigned Filter_Depth = 3,
    parameter int unsigned Hold_Cycles  = 2
) (
    input  logic       ipClk,
    input  logic       ipnReset,
    input  logic       ipSClk,
    output logic       opSClk,
    input  logic       ipData,
    output logic       opData,
    output logic       opSelected,
    output logic       opR_nW,
    output logic       opStart,
    output logic       opStop,
    output logic [7:0] opRxData,
    output logic       opRxValid,
    output logic       opTxReq,
    input  logic [7:0] ipTxData,
    input  logic       ipTxValid,
    output logic       opTxNack
);
    localparam int unsigned CNT_W  = $clog2(Filter_Depth + 1);
    localparam int unsigned HOLD_W = $clog2(Hold_Cycles + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_LOAD, S_TX_BYTE, S_TX_ACK
    } state_e;

    // Bit 1 carries SCL, bit 0 carries SDA through the input path.
    logic [1:0]       sync1_q, sync2_q, flt_q, flt_d, prev_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d, rx_data_q, rx_data_d;
    logic              rnw_q, rnw_d, sel_q, sel_d, sda_out_q, sda_out_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_q, start_d, stop_q, stop_d, rx_valid_q, rx_valid_d;
    logic              tx_req_q, tx_req_d, tx_nack_q, tx_nack_d;
    logic              scl_rise, scl_fall, start_det, stop_det, sda_in, drive_bit;
`ifdef I2C_TARGET_STRETCH_EN
    logic              scl_out_q, scl_out_d;
    logic [HOLD_W-1:0] rel_q, rel_d;
`endif

    always_comb begin
        flt_d = flt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == flt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(Filter_Depth - 1)) begin
                flt_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign scl_rise  =  flt_q[1] & ~prev_q[1];
    assign scl_fall  = ~flt_q[1] &  prev_q[1];
    assign start_det =  prev_q[0] & ~flt_q[0] & flt_q[1] & prev_q[1];
    assign stop_det  = ~prev_q[0] &  flt_q[0] & flt_q[1] & prev_q[1];
    assign sda_in    = flt_q[0];

    always_comb begin
        case (state_q)
            S_ADDR_ACK, S_RX_ACK: drive_bit = 1'b0;
            S_TX_BYTE:            drive_bit = tx_q[7];
            default:              drive_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        rnw_d      = rnw_q;
        sel_d      = sel_q;
        sda_out_d  = sda_out_q;
        hold_d     = hold_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        tx_nack_d  = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
        scl_out_d  = scl_out_q;
        rel_d      = rel_q;
        if (rel_q != '0) begin
            rel_d = rel_q - 1'b1;
            if (rel_q == HOLD_W'(1)) scl_out_d = 1'b1;
        end
`endif
        // SDA only moves when the hold timer armed by an SCL fall expires.
        if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) begin
                sda_out_d = drive_bit;
`ifdef I2C_TARGET_STRETCH_EN
                if (state_q == S_TX_BYTE && !scl_out_q) rel_d = HOLD_W'(Hold_Cycles);
`endif
            end
        end

        if (start_det) begin
            start_d   = 1'b1;
            sel_d     = 1'b0;
            sda_out_d = 1'b1;
            hold_d    = '0;
            bit_cnt_d = '0;
            state_d   = S_ADDR;
`ifdef I2C_TARGET_STRETCH_EN
            scl_out_d = 1'b1;
            rel_d     = '0;
`endif
        end else if (stop_det) begin
            stop_d    = 1'b1;
            sel_d     = 1'b0;
            sda_out_d = 1'b1;
            hold_d    = '0;
            state_d   = S_IDLE;
`ifdef I2C_TARGET_STRETCH_EN
            scl_out_d = 1'b1;
            rel_d     = '0;
`endif
        end else begin
            if (scl_fall) hold_d = HOLD_W'(Hold_Cycles);
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[5:0], sda_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_q == Address) begin
                            rnw_d   = sda_in;
                            sel_d   = 1'b1;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_rise) begin
                    bit_cnt_d = '0;
                    if (rnw_q) begin
                        tx_req_d = 1'b1;
                        state_d  = S_TX_LOAD;
                    end else begin
                        state_d  = S_RX_BYTE;
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    shift_d   = {shift_q[5:0], sda_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q, sda_in};
                        rx_valid_d = 1'b1;
                        state_d    = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_rise) begin
                    bit_cnt_d = '0;
                    state_d   = S_RX_BYTE;
                end
                S_TX_LOAD: begin
`ifdef I2C_TARGET_STRETCH_EN
                    if (scl_fall) begin
                        scl_out_d = 1'b0;
                    end else if (!scl_out_q && ipTxValid) begin
                        tx_d      = ipTxData;
                        bit_cnt_d = '0;
                        hold_d    = HOLD_W'(Hold_Cycles);
                        state_d   = S_TX_BYTE;
                    end
`else
                    if (scl_fall) begin
                        tx_d      = ipTxValid ? ipTxData : 8'hFF;
                        bit_cnt_d = '0;
                        state_d   = S_TX_BYTE;
                    end
`endif
                end
                S_TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_d = S_TX_ACK;
                    end
                    if (scl_fall) tx_d = {tx_q[6:0], 1'b1};
                end
                S_TX_ACK: if (scl_rise) begin
                    if (sda_in) begin
                        tx_nack_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        tx_req_d  = 1'b1;
                        state_d   = S_TX_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            flt_q      <= '1;
            prev_q     <= '1;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '1;
            rx_data_q  <= '0;
            rnw_q      <= 1'b0;
            sel_q      <= 1'b0;
            sda_out_q  <= 1'b1;
            hold_q     <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_nack_q  <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_out_q  <= 1'b1;
            rel_q      <= '0;
`endif
        end else begin
            sync1_q    <= {ipSClk, ipData};
            sync2_q    <= sync1_q;
            flt_q      <= flt_d;
            prev_q     <= flt_q;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rx_data_q  <= rx_data_d;
            rnw_q      <= rnw_d;
            sel_q      <= sel_d;
            sda_out_q  <= sda_out_d;
            hold_q     <= hold_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            tx_nack_q  <= tx_nack_d;
`ifdef I2C_TARGET_STRETCH_EN
            scl_out_q  <= scl_out_d;
            rel_q      <= rel_d;
`endif
        end
    end

`ifdef I2C_TARGET_STRETCH_EN
    assign opSClk = scl_out_q;
`else
    assign opSClk = 1'b1;
`endif
    assign opData     = sda_out_q;
    assign opSelected = sel_q;
    assign opR_nW     = rnw_q;
    assign opStart    = start_q;
    assign opStop     = stop_q;
    assign opRxData   = rx_data_q;
    assign opRxValid  = rx_valid_q;
    assign opTxReq    = tx_req_q;
    assign opTxNack   = tx_nack_q;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C initiator on a wired-AND bus with a read-data responder.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 20;

    logic       ipClk = 1'b0;
    logic       ipnReset, scl_drv, sda_drv;
    logic       ipSClk, ipData;
    logic       opSClk, opData, opSelected, opR_nW, opStart, opStop;
    logic [7:0] opRxData, ipTxData;
    logic       opRxValid, opTxReq, ipTxValid, opTxNack;

    int vec = 0, errs = 0;
    int n_start = 0, n_stop = 0, n_rx = 0, n_req = 0, n_nack = 0, n_sel = 0;
    int low_run = 0, max_low = 0;
    logic [7:0] rx_log [64];
    logic [7:0] tx_tab [16];
    int  resp_idx;
    bit  resp_en = 1'b1;
    int  resp_delay = 0;

    always #5 ipClk = ~ipClk;

    assign ipSClk = scl_drv & opSClk;
    assign ipData = sda_drv & opData;

    i2c_target dut (
        .ipClk(ipClk), .ipnReset(ipnReset),
        .ipSClk(ipSClk), .opSClk(opSClk), .ipData(ipData), .opData(opData),
        .opSelected(opSelected), .opR_nW(opR_nW), .opStart(opStart), .opStop(opStop),
        .opRxData(opRxData), .opRxValid(opRxValid), .opTxReq(opTxReq),
        .ipTxData(ipTxData), .ipTxValid(ipTxValid), .opTxNack(opTxNack)
    );

    always @(negedge ipClk) begin
        if (ipnReset) begin
            n_start += int'(opStart);
            n_stop  += int'(opStop);
            n_req   += int'(opTxReq);
            n_nack  += int'(opTxNack);
            n_sel   += int'(opSelected);
            if (opRxValid && n_rx < 64) begin
                rx_log[n_rx] = opRxData;
                n_rx++;
            end
            if (!opSClk) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
        end
    end

    initial begin
        ipTxData  = 8'h00;
        ipTxValid = 1'b0;
        resp_idx  = 0;
        forever begin
            @(negedge ipClk);
            if (opTxReq) begin
                ipTxValid = 1'b0;
                if (resp_en) begin
                    repeat (resp_delay) @(negedge ipClk);
                    ipTxData  = tx_tab[resp_idx];
                    resp_idx++;
                    ipTxValid = 1'b1;
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no completion, expected summary before 90000 cycles");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge ipClk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (!ipSClk && n < 3000) begin
            @(negedge ipClk);
            n++;
        end
        if (!ipSClk) chk("scl_release_timeout", 32'(ipSClk), 32'd1);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; wait_scl_high(); qwait();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b1; wait_scl_high(); qwait();
        sda_drv = 1'b1; qwait(); qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; qwait();
        scl_drv = 1'b1; wait_scl_high(); qwait(); qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; wait_scl_high(); qwait();
        b = ipData; qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int b_start, b_stop, b_rx, b_req, b_nack, b_sel;

        ipnReset = 1'b0;
        scl_drv  = 1'b1;
        sda_drv  = 1'b1;
        repeat (5) @(negedge ipClk);
        chk("rst_scl",      32'(opSClk),     32'd1);
        chk("rst_sda",      32'(opData),     32'd1);
        chk("rst_selected", 32'(opSelected), 32'd0);
        chk("rst_rnw",      32'(opR_nW),     32'd0);
        chk("rst_rxdata",   32'(opRxData),   32'h00);
        chk("rst_pulses",   32'({opStart, opStop, opRxValid, opTxReq, opTxNack}), 32'd0);
        ipnReset = 1'b1;
        repeat (10) @(negedge ipClk);

        // Write 0x50+W, 0xA5, 0x3C, STOP
        b_start = n_start; b_stop = n_stop; b_rx = n_rx;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'd0);
        chk("wr_selected", 32'(opSelected), 32'd1);
        chk("wr_rnw", 32'(opR_nW), 32'd0);
        write_byte(8'hA5, ack);
        chk("wr_b0_ack", 32'(ack), 32'd0);
        chk("wr_b0_rxdata", 32'(opRxData), 32'hA5);
        write_byte(8'h3C, ack);
        chk("wr_b1_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("wr_start_cnt", 32'(n_start - b_start), 32'd1);
        chk("wr_stop_cnt", 32'(n_stop - b_stop), 32'd1);
        chk("wr_rxvalid_cnt", 32'(n_rx - b_rx), 32'd2);
        chk("wr_rx_log0", 32'(rx_log[b_rx]), 32'hA5);
        chk("wr_rx_log1", 32'(rx_log[b_rx + 1]), 32'h3C);
        chk("wr_sel_after_stop", 32'(opSelected), 32'd0);

        // Wrong address 0x51+W
        b_rx = n_rx; b_sel = n_sel;
        i2c_start();
        write_byte(8'hA2, ack);
        chk("bad_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h77, ack);
        i2c_stop();
        chk("bad_addr_sel_cycles", 32'(n_sel - b_sel), 32'd0);
        chk("bad_addr_rxvalid", 32'(n_rx - b_rx), 32'd0);

        // Read 0x50+R: 0x96 ACK, 0x01 NACK
        tx_tab[resp_idx] = 8'h96; tx_tab[resp_idx + 1] = 8'h01;
        b_req = n_req; b_nack = n_nack;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'd0);
        chk("rd_rnw", 32'(opR_nW), 32'd1);
        read_byte(d, 1'b0);
        chk("rd_byte0", 32'(d), 32'h96);
        read_byte(d, 1'b1);
        chk("rd_byte1", 32'(d), 32'h01);
        i2c_stop();
        chk("rd_txreq_cnt", 32'(n_req - b_req), 32'd2);
        chk("rd_txnack_cnt", 32'(n_nack - b_nack), 32'd1);

`ifdef I2C_TARGET_STRETCH_EN
        // Slow responder: SCL stretched until data is valid
        tx_tab[resp_idx] = 8'hC3;
        resp_delay = 560;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("st_addr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b1);
        chk("st_byte", 32'(d), 32'hC3);
        i2c_stop();
        chk("st_held_500", 32'(max_low >= 500), 32'd1);
        resp_delay = 0;
`else
        // No data offered: 0xFF goes out, SCL never driven
        resp_en = 1'b0;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("ff_addr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b1);
        chk("ff_byte", 32'(d), 32'hFF);
        i2c_stop();
        chk("ff_scl_never_low", 32'(max_low), 32'd0);
        resp_en = 1'b1;
`endif

        // Write 0x11, repeated START, read
        tx_tab[resp_idx] = 8'h5E;
        b_start = n_start;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        chk("rs_wr_ack", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rs_addr_ack", 32'(ack), 32'd0);
        chk("rs_rxdata", 32'(opRxData), 32'h11);
        chk("rs_start_cnt", 32'(n_start - b_start), 32'd2);
        chk("rs_rnw", 32'(opR_nW), 32'd1);
        read_byte(d, 1'b1);
        chk("rs_rd_byte", 32'(d), 32'h5E);
        i2c_stop();

        // Reset in the 4th bit of a read while the target drives SDA low
        tx_tab[resp_idx] = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 3; i++) read_bit(b);
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; wait_scl_high(); qwait();
        chk("rstmid_driving_low", 32'(opData), 32'd0);
        ipnReset = 1'b0;
        #1;
        chk("rstmid_sda_released", 32'(opData), 32'd1);
        chk("rstmid_scl_released", 32'(opSClk), 32'd1);
        chk("rstmid_sel_cleared", 32'(opSelected), 32'd0);
        repeat (10) @(negedge ipClk);
        ipnReset = 1'b1;
        repeat (20) @(negedge ipClk);
        b_rx = n_rx;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("rstmid_restart_ack", 32'(ack), 32'd0);
        write_byte(8'h5A, ack);
        i2c_stop();
        chk("rstmid_rx_cnt", 32'(n_rx - b_rx), 32'd1);
        chk("rstmid_rxdata", 32'(opRxData), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
